// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the memory-side initiator.
// Pure definitions: no logic, no latency.
// Backpressure is handled by the modules that import this package.
package axi_pkg;

    // Burst type: this block only issues incrementing bursts
    localparam logic [1:0] BURST_INCR    = 2'b01;

    // Response encodings; bit 1 set means the slave reported an error
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_EXOKAY   = 2'b01;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam logic [1:0] RESP_DECERR   = 2'b11;

    // Normal non-cacheable bufferable memory attributes
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // A single AXI burst must never cross this byte boundary
    localparam int unsigned BOUNDARY_4K  = 4096;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_AR,
        RD_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_AW,
        WR_DATA,
        WR_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_burst_split.sv
// Chops a request into the largest burst that stays inside the current 4 KB page.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds addr/remaining stable while it needs the result.
module axi_burst_split
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [8:0]            remaining_i,
    output logic [8:0]            beats_o,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    localparam int SIZE = $clog2(STRB_WIDTH);

    logic [12:0]           bytes_to_4k;
    logic [12:0]           beats_to_4k;
    logic [8:0]            beats;
    logic [ADDR_WIDTH-1:0] step;

    // Burst beats = min(remaining, beats left in the page); next address wraps modulo 2^ADDR_WIDTH
    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_i[11:0]};
        beats_to_4k = bytes_to_4k >> SIZE;
        if ({4'b0000, remaining_i} < beats_to_4k) begin
            beats = remaining_i;
        end else begin
            beats = beats_to_4k[8:0];
        end
        step        = ADDR_WIDTH'(beats) << SIZE;
        next_addr_o = addr_i + step;
        beats_o     = beats;
    end

endmodule

// File: rtl/axi_mem_master.sv
// AXI4 initiator: turns read/write commands plus data streams into 4 KB-safe INCR bursts.
// Latency: AR/AW one cycle after command accept; R and W data paths are combinational pass-through.
// Backpressure: one burst outstanding per path; streams stall directly on rready/wready from the bus.
module axi_mem_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    // Read command and stream
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic [7:0]            rd_cmd_len,
    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_last,
    output logic                  rd_data_err,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,

    // Write command, stream and completion
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [7:0]            wr_cmd_len,
    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    output logic                  wr_done,
    output logic                  wr_done_err,

    // AXI write address
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    // AXI write data
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    // AXI write response
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    // AXI read address
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // AXI read data
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0]            AXI_SIZE  = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e             rd_state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic [8:0]            rd_rem_q;
    logic [8:0]            rd_rem_d;
    logic [8:0]            rd_burst_beats;
    logic [8:0]            rd_len_m1;
    logic                  rd_cmd_ready_q;
    logic                  arvalid_q;
    logic                  rd_in_data;
    logic                  rd_last_hs;

    axi_burst_split #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_rd_split (
        .addr_i      (rd_addr_q),
        .remaining_i (rd_rem_q),
        .beats_o     (rd_burst_beats),
        .next_addr_o (rd_addr_d)
    );

    assign rd_rem_d   = rd_rem_q - rd_burst_beats;
    assign rd_len_m1  = rd_burst_beats - 9'd1;
    assign rd_in_data = (rd_state_q == RD_DATA);
    assign rd_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Read FSM: accept command, issue one AR per page-bounded burst, return to idle after the final rlast
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q     <= RD_IDLE;
            rd_addr_q      <= '0;
            rd_rem_q       <= '0;
            rd_cmd_ready_q <= 1'b1;
            arvalid_q      <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_cmd_valid && rd_cmd_ready_q) begin
                        rd_addr_q      <= rd_cmd_addr & ADDR_MASK;
                        rd_rem_q       <= {1'b0, rd_cmd_len} + 9'd1;
                        rd_cmd_ready_q <= 1'b0;
                        arvalid_q      <= 1'b1;
                        rd_state_q     <= RD_AR;
                    end
                end
                RD_AR: begin
                    // Address/len stay derived from unchanged state until the handshake
                    if (m_axi_arready) begin
                        arvalid_q  <= 1'b0;
                        rd_addr_q  <= rd_addr_d;
                        rd_rem_q   <= rd_rem_d;
                        rd_state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rd_last_hs) begin
                        if (rd_rem_q != 9'd0) begin
                            arvalid_q  <= 1'b1;
                            rd_state_q <= RD_AR;
                        end else begin
                            rd_cmd_ready_q <= 1'b1;
                            rd_state_q     <= RD_IDLE;
                        end
                    end
                end
                default: begin
                    rd_state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign rd_cmd_ready  = rd_cmd_ready_q;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = rd_addr_q;
    assign m_axi_arlen   = rd_len_m1[7:0];
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_DEFAULT;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;

    // R channel passes straight through; rem already excludes the current burst, so zero marks the final one
    assign rd_data       = m_axi_rdata;
    assign rd_data_err   = m_axi_rresp[1];
    assign rd_data_valid = rd_in_data && m_axi_rvalid;
    assign rd_data_last  = m_axi_rlast && (rd_rem_q == 9'd0);
    assign m_axi_rready  = rd_in_data && rd_data_ready;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e             wr_state_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [8:0]            wr_rem_q;
    logic [8:0]            wr_rem_d;
    logic [8:0]            wr_burst_beats;
    logic [8:0]            wr_len_m1;
    logic [7:0]            wr_cnt_q;
    logic                  wr_err_q;
    logic                  wr_cmd_ready_q;
    logic                  awvalid_q;
    logic                  bready_q;
    logic                  wr_done_q;
    logic                  wr_done_err_q;
    logic                  wr_in_data;
    logic                  wr_w_hs;

    axi_burst_split #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_wr_split (
        .addr_i      (wr_addr_q),
        .remaining_i (wr_rem_q),
        .beats_o     (wr_burst_beats),
        .next_addr_o (wr_addr_d)
    );

    assign wr_rem_d   = wr_rem_q - wr_burst_beats;
    assign wr_len_m1  = wr_burst_beats - 9'd1;
    assign wr_in_data = (wr_state_q == WR_DATA);
    assign wr_w_hs    = m_axi_wvalid && m_axi_wready;

    // Write FSM: AW, then W beats counted down to wlast, then B; loops per burst and reports completion once
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q     <= WR_IDLE;
            wr_addr_q      <= '0;
            wr_rem_q       <= '0;
            wr_cnt_q       <= '0;
            wr_err_q       <= 1'b0;
            wr_cmd_ready_q <= 1'b1;
            awvalid_q      <= 1'b0;
            bready_q       <= 1'b0;
            wr_done_q      <= 1'b0;
            wr_done_err_q  <= 1'b0;
        end else begin
            wr_done_q     <= 1'b0;
            wr_done_err_q <= 1'b0;
            case (wr_state_q)
                WR_IDLE: begin
                    if (wr_cmd_valid && wr_cmd_ready_q) begin
                        wr_addr_q      <= wr_cmd_addr & ADDR_MASK;
                        wr_rem_q       <= {1'b0, wr_cmd_len} + 9'd1;
                        wr_err_q       <= 1'b0;
                        wr_cmd_ready_q <= 1'b0;
                        awvalid_q      <= 1'b1;
                        wr_state_q     <= WR_AW;
                    end
                end
                WR_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q  <= 1'b0;
                        wr_addr_q  <= wr_addr_d;
                        wr_rem_q   <= wr_rem_d;
                        wr_cnt_q   <= wr_len_m1[7:0];
                        wr_state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (wr_w_hs) begin
                        if (wr_cnt_q == 8'd0) begin
                            bready_q   <= 1'b1;
                            wr_state_q <= WR_RESP;
                        end else begin
                            wr_cnt_q <= wr_cnt_q - 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    // bready is already high here, so bvalid alone marks the handshake
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        wr_err_q <= wr_err_q | m_axi_bresp[1];
                        if (wr_rem_q != 9'd0) begin
                            awvalid_q  <= 1'b1;
                            wr_state_q <= WR_AW;
                        end else begin
                            wr_done_q      <= 1'b1;
                            wr_done_err_q  <= wr_err_q | m_axi_bresp[1];
                            wr_cmd_ready_q <= 1'b1;
                            wr_state_q     <= WR_IDLE;
                        end
                    end
                end
                default: begin
                    wr_state_q <= WR_IDLE;
                end
            endcase
        end
    end

    assign wr_cmd_ready  = wr_cmd_ready_q;
    assign wr_done       = wr_done_q;
    assign wr_done_err   = wr_done_err_q;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = wr_addr_q;
    assign m_axi_awlen   = wr_len_m1[7:0];
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_DEFAULT;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;

    // W is only opened after the AW handshake, which keeps address ahead of data
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign m_axi_wlast   = wr_in_data && (wr_cnt_q == 8'd0);
    assign m_axi_wvalid  = wr_in_data && wr_data_valid;
    assign wr_data_ready = wr_in_data && m_axi_wready;
    assign m_axi_bready  = bready_q;

    // IDs are not checked (single fixed ID) and only the error bit of a response matters
    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0],
                         rd_len_m1[8], wr_len_m1[8]};

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed bench for axi_mem_master with a small in-bench AXI slave model.
module tb_axi_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] rd_cmd_addr = '0;
    logic [7:0]  rd_cmd_len = '0;
    logic        rd_cmd_valid = 1'b0;
    logic        rd_cmd_ready;
    logic [31:0] rd_data;
    logic        rd_data_last, rd_data_err, rd_data_valid;
    logic        rd_data_ready = 1'b0;

    logic [15:0] wr_cmd_addr = '0;
    logic [7:0]  wr_cmd_len = '0;
    logic        wr_cmd_valid = 1'b0;
    logic        wr_cmd_ready;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_data_valid = 1'b0;
    logic        wr_data_ready, wr_done, wr_done_err;

    logic [7:0]  m_axi_awid, m_axi_arid;
    logic [15:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache;
    logic        m_axi_awvalid, m_axi_arvalid;
    logic        m_axi_awready = 1'b0, m_axi_arready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [7:0]  m_axi_bid = '0, m_axi_rid = '0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic        m_axi_bvalid = 1'b0, m_axi_bready;
    logic [31:0] m_axi_rdata = '0;
    logic        m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;

    axi_mem_master #(
        .DATA_WIDTH (32), .ADDR_WIDTH (16), .ID_WIDTH (8), .AXI_ID (0)
    ) dut (
        .clk (clk), .rst (rst),
        .rd_cmd_addr (rd_cmd_addr), .rd_cmd_len (rd_cmd_len),
        .rd_cmd_valid (rd_cmd_valid), .rd_cmd_ready (rd_cmd_ready),
        .rd_data (rd_data), .rd_data_last (rd_data_last), .rd_data_err (rd_data_err),
        .rd_data_valid (rd_data_valid), .rd_data_ready (rd_data_ready),
        .wr_cmd_addr (wr_cmd_addr), .wr_cmd_len (wr_cmd_len),
        .wr_cmd_valid (wr_cmd_valid), .wr_cmd_ready (wr_cmd_ready),
        .wr_data (wr_data), .wr_strb (wr_strb),
        .wr_data_valid (wr_data_valid), .wr_data_ready (wr_data_ready),
        .wr_done (wr_done), .wr_done_err (wr_done_err),
        .m_axi_awid (m_axi_awid), .m_axi_awaddr (m_axi_awaddr), .m_axi_awlen (m_axi_awlen),
        .m_axi_awsize (m_axi_awsize), .m_axi_awburst (m_axi_awburst), .m_axi_awlock (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache), .m_axi_awprot (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
        .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wlast (m_axi_wlast),
        .m_axi_wvalid (m_axi_wvalid), .m_axi_wready (m_axi_wready),
        .m_axi_bid (m_axi_bid), .m_axi_bresp (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready),
        .m_axi_arid (m_axi_arid), .m_axi_araddr (m_axi_araddr), .m_axi_arlen (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize), .m_axi_arburst (m_axi_arburst), .m_axi_arlock (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache), .m_axi_arprot (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid), .m_axi_arready (m_axi_arready),
        .m_axi_rid (m_axi_rid), .m_axi_rdata (m_axi_rdata), .m_axi_rresp (m_axi_rresp),
        .m_axi_rlast (m_axi_rlast), .m_axi_rvalid (m_axi_rvalid), .m_axi_rready (m_axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Recorded read activity
    logic [15:0] ar_addr_r [0:7];
    logic [7:0]  ar_len_r  [0:7];
    logic [2:0]  ar_size_r [0:7];
    logic [1:0]  ar_burst_r[0:7];
    int          ar_n, ar_first, rx_n, stall_hi, last_n, last_pos, dat_bad;
    logic        rx_err [0:63];
    logic        ready_at_last;

    // Recorded write activity
    logic [15:0] aw_addr_r [0:7];
    logic [7:0]  aw_len_r  [0:7];
    int          aw_n, wlast_n, wdat_bad, wviol, done_n, b_n, widx;
    int          wlast_pos [0:3];
    logic        done_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input logic [15:0] addr, input logic [7:0] len);
        int n = 0;
        rd_cmd_addr  = addr;
        rd_cmd_len   = len;
        rd_cmd_valid = 1'b1;
        #1;
        while (!rd_cmd_ready && n < 50) begin
            tick(); #1; n++;
        end
        if (n >= 50) chk("rd_cmd_timeout", 0, 1);
        tick();
        rd_cmd_valid = 1'b0;
    endtask

    task automatic issue_wr(input logic [15:0] addr, input logic [7:0] len);
        int n = 0;
        wr_cmd_addr  = addr;
        wr_cmd_len   = len;
        wr_cmd_valid = 1'b1;
        #1;
        while (!wr_cmd_ready && n < 50) begin
            tick(); #1; n++;
        end
        if (n >= 50) chk("wr_cmd_timeout", 0, 1);
        tick();
        wr_cmd_valid = 1'b0;
    endtask

    // Slave model for reads: grants AR at once, streams beats D000_0000+n, rresp SLVERR on beat 2
    task automatic run_read(input int stall_at, input int stall_len);
        int  cyc = 0;
        int  left = 0;
        int  beat = 0;
        bit  in_burst = 0;
        bit  done = 0;
        ar_n = 0; ar_first = -1; rx_n = 0; stall_hi = 0;
        last_n = 0; last_pos = -1; dat_bad = 0; ready_at_last = 1'b1;
        while (!done && cyc < 2000) begin
            m_axi_arready = 1'b1;
            m_axi_rvalid  = in_burst;
            m_axi_rdata   = 32'hD000_0000 + beat;
            m_axi_rlast   = (left == 1);
            m_axi_rresp   = (beat == 2) ? 2'b10 : 2'b00;
            rd_data_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (!rd_data_ready && m_axi_rready) stall_hi++;
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_first < 0) ar_first = cyc;
                if (ar_n < 8) begin
                    ar_addr_r[ar_n]  = m_axi_araddr;
                    ar_len_r[ar_n]   = m_axi_arlen;
                    ar_size_r[ar_n]  = m_axi_arsize;
                    ar_burst_r[ar_n] = m_axi_arburst;
                end
                ar_n++;
                in_burst = 1;
                left = int'(m_axi_arlen) + 1;
            end else if (m_axi_rvalid && m_axi_rready) begin
                if (!rd_data_valid || rd_data !== 32'hD000_0000 + beat) dat_bad++;
                if (rx_n < 64) rx_err[rx_n] = rd_data_err;
                if (rd_data_last) begin
                    last_n++;
                    last_pos = rx_n;
                end
                rx_n++;
                beat++;
                left--;
                if (left == 0) begin
                    in_burst = 0;
                    if (rd_data_last) begin
                        done = 1;
                        ready_at_last = rd_cmd_ready;
                    end
                end
            end
            tick();
            cyc++;
        end
        if (!done) chk("rd_timeout", 0, 1);
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        rd_data_ready = 1'b0;
    endtask

    // Slave model for writes: optional random AW/W stalls, B two cycles after wlast with scripted resp
    task automatic run_write(input bit rnd, input int abort_at,
                             input logic [1:0] br0, input logic [1:0] br1);
        int cyc = 0;
        int post = 0;
        int bdly = 0;
        bit bpend = 0;
        bit aw_open = 0;
        aw_n = 0; wlast_n = 0; wdat_bad = 0; wviol = 0; done_n = 0; b_n = 0; widx = 0;
        done_err = 1'b0;
        while (cyc < 5000 && !(abort_at > 0 && widx == abort_at) && post < 3) begin
            m_axi_awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_axi_wready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_axi_bvalid  = bpend && (bdly == 0);
            m_axi_bresp   = (b_n == 0) ? br0 : br1;
            wr_data_valid = 1'b1;
            wr_data       = 32'hC000_0000 + widx;
            wr_strb       = 4'hF;
            #1;
            if (wr_done) begin
                done_n++;
                done_err = wr_done_err;
            end
            if (m_axi_wvalid && !aw_open) wviol++;
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wdata !== 32'hC000_0000 + widx || m_axi_wstrb !== 4'hF || !wr_data_ready)
                    wdat_bad++;
                if (m_axi_wlast) begin
                    if (wlast_n < 4) wlast_pos[wlast_n] = widx;
                    wlast_n++;
                    aw_open = 0;
                    bpend = 1;
                    bdly = 2;
                end
                widx++;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_n < 8) begin
                    aw_addr_r[aw_n] = m_axi_awaddr;
                    aw_len_r[aw_n]  = m_axi_awlen;
                end
                aw_n++;
                aw_open = 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                bpend = 0;
                b_n++;
            end else if (bpend && bdly > 0) begin
                bdly--;
            end
            if (done_n > 0) post++;
            tick();
            cyc++;
        end
        if (abort_at == 0 && done_n == 0) chk("wr_timeout", 0, 1);
        m_axi_bvalid  = 1'b0;
        wr_data_valid = 1'b0;
    endtask

    initial begin
        // Reset state, checked while reset is held and after release
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_rd_cmd_ready", rd_cmd_ready, 1);
        chk("rst_wr_cmd_ready", wr_cmd_ready, 1);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_awvalid", m_axi_awvalid, 0);
        rst = 1'b0;
        tick();
        chk("idle_wvalid", m_axi_wvalid, 0);
        chk("idle_bready", m_axi_bready, 0);
        chk("idle_wr_done", {wr_done, wr_done_err}, 0);
        chk("idle_rd_data_valid", rd_data_valid, 0);
        chk("const_cache", {m_axi_arcache, m_axi_awcache}, 8'h33);
        chk("const_lock_prot", {m_axi_arlock, m_axi_awlock, m_axi_arprot, m_axi_awprot}, 0);
        chk("const_aw_size_burst", {m_axi_awsize, m_axi_awburst, m_axi_awid}, {3'd2, 2'b01, 8'h00});

        // Single-beat read
        issue_rd(16'h0100, 8'd0);
        run_read(1000, 0);
        chk("r1_ar_n", ar_n, 1);
        chk("r1_ar_first_cycle", ar_first, 0);
        chk("r1_araddr", ar_addr_r[0], 16'h0100);
        chk("r1_arlen", ar_len_r[0], 0);
        chk("r1_arsize_burst", {ar_size_r[0], ar_burst_r[0]}, {3'd2, 2'b01});
        chk("r1_beats", rx_n, 1);
        chk("r1_last", {last_n[7:0], last_pos[7:0]}, {8'd1, 8'd0});
        chk("r1_data", dat_bad, 0);
        chk("r1_ready_at_rlast", ready_at_last, 0);
        chk("r1_ready_after", rd_cmd_ready, 1);

        // Read crossing 4 KB: split into two 4-beat bursts
        issue_rd(16'h0FF0, 8'd7);
        run_read(1000, 0);
        chk("r2_ar_n", ar_n, 2);
        chk("r2_ar0", {ar_addr_r[0], ar_len_r[0]}, {16'h0FF0, 8'd3});
        chk("r2_ar1", {ar_addr_r[1], ar_len_r[1]}, {16'h1000, 8'd3});
        chk("r2_beats", rx_n, 8);
        chk("r2_last_only_8th", {last_n[7:0], last_pos[7:0]}, {8'd1, 8'd7});
        chk("r2_data", dat_bad, 0);
        chk("r2_err_bits", {rx_err[1], rx_err[2], rx_err[3]}, 3'b010);

        // Read with 10-cycle consumer stall mid-burst
        issue_rd(16'h0200, 8'd15);
        run_read(5, 10);
        chk("r3_ar", {ar_n[7:0], ar_addr_r[0], ar_len_r[0]}, {8'd1, 16'h0200, 8'd15});
        chk("r3_rready_in_stall", stall_hi, 0);
        chk("r3_beats", rx_n, 16);
        chk("r3_data_order", dat_bad, 0);

        // 256-beat write with random AW/W stalls
        issue_wr(16'h0000, 8'd255);
        run_write(1'b1, 0, 2'b00, 2'b00);
        chk("w1_aw", {aw_n[7:0], aw_addr_r[0], aw_len_r[0]}, {8'd1, 16'h0000, 8'd255});
        chk("w1_beats", widx, 256);
        chk("w1_wlast", {wlast_n[15:0], wlast_pos[0][15:0]}, {16'd1, 16'd255});
        chk("w1_wdata", wdat_bad, 0);
        chk("w1_w_before_aw", wviol, 0);
        chk("w1_done", {done_n[7:0], 7'd0, done_err}, {8'd1, 8'd0});

        // Write crossing 4 KB, first response SLVERR
        issue_wr(16'h0FF8, 8'd3);
        run_write(1'b0, 0, 2'b10, 2'b00);
        chk("w2_aw_n", aw_n, 2);
        chk("w2_aw0", {aw_addr_r[0], aw_len_r[0]}, {16'h0FF8, 8'd1});
        chk("w2_aw1", {aw_addr_r[1], aw_len_r[1]}, {16'h1000, 8'd1});
        chk("w2_wlast", {wlast_n[7:0], wlast_pos[0][7:0], wlast_pos[1][7:0]}, {8'd2, 8'd1, 8'd3});
        chk("w2_w_before_aw", wviol, 0);
        chk("w2_done_err", {done_n[7:0], 7'd0, done_err}, {8'd1, 8'd1});

        // Reset in the middle of a write data phase
        issue_wr(16'h0040, 8'd7);
        run_write(1'b0, 3, 2'b00, 2'b00);
        wr_data_valid = 1'b1;
        m_axi_wready  = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_mid_wvalid", m_axi_wvalid, 0);
        chk("rst_mid_awvalid", m_axi_awvalid, 0);
        chk("rst_mid_wr_cmd_ready", wr_cmd_ready, 1);
        rst = 1'b0;
        wr_data_valid = 1'b0;
        tick();
        issue_wr(16'h0080, 8'd1);
        run_write(1'b0, 0, 2'b00, 2'b00);
        chk("w3_aw", {aw_n[7:0], aw_addr_r[0], aw_len_r[0]}, {8'd1, 16'h0080, 8'd1});
        chk("w3_wlast", {wlast_n[7:0], wlast_pos[0][7:0]}, {8'd1, 8'd1});
        chk("w3_done", {done_n[7:0], 7'd0, done_err}, {8'd1, 8'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_master.md
Name: axi_mem_master

Overview:
AXI4 master (initiator) that turns simple command/stream requests into INCR bursts on an AXI4 bus. It is the initiator-side counterpart of our AXI-to-memory slave adapters. It sits between a core-side engine (DMA/packet mover) and an AXI interconnect or slave. Read and write paths are fully independent; each path has at most one burst outstanding. Any request that crosses a 4 KB boundary is split automatically.

Parameters:
DATA_WIDTH, 32, AXI data width in bits; power of two, at least 8.
ADDR_WIDTH, 16, byte address width; at least 12.
ID_WIDTH, 8, AXI ID width.
AXI_ID, 0, constant ID driven on AW and AR.
STRB_WIDTH, DATA_WIDTH/8, derived; byte lanes per beat.

Ports:
clk  in  1  clock
rst  in  1  reset
rd_cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits are ignored and forced to 0
rd_cmd_len  in  8  number of beats minus 1 (1..256 beats)
rd_cmd_valid / rd_cmd_ready  in / out  1  read command handshake
rd_data  out  DATA_WIDTH  read beat
rd_data_last  out  1  final beat of the whole command
rd_data_err  out  1  rresp[1] of this beat
rd_data_valid / rd_data_ready  out / in  1  read stream handshake
wr_cmd_addr, wr_cmd_len, wr_cmd_valid / wr_cmd_ready  as for rd_cmd
wr_data  in  DATA_WIDTH  write beat
wr_strb  in  STRB_WIDTH  write byte strobes
wr_data_valid / wr_data_ready  in / out  1  write stream handshake
wr_done  out  1  one-cycle pulse when a write command completes
wr_done_err  out  1  OR of bresp[1] over all bursts of the command; valid with wr_done
m_axi_aw*  out  awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid; awready in
m_axi_w*  out  wdata, wstrb, wlast, wvalid; wready in
m_axi_b*  in  bid, bresp[1:0], bvalid; bready out
m_axi_ar*  out  arid, araddr, arlen, arsize, arburst, arvalid; arready in
m_axi_r*  in  rid, rdata, rresp, rlast, rvalid; rready out
m_axi_{aw,ar}lock/cache/prot  out  1/4/3  constants 0 / 4'b0011 / 3'b000

Behaviour:
- Reset: synchronous, active-high, on rst in clk domain. During and after reset:
  - rd_cmd_ready = 1 and wr_cmd_ready = 1 (IDLE).
  - All valid outputs = 0, wr_done = 0, wr_done_err = 0, bready = 0.
  - Reset mid-operation silently drops in-flight commands; the AXI slave must be reset at the same time.
- Constant fields: awsize/arsize = log2(STRB_WIDTH); awburst/arburst = 2'b01 (INCR); awid/arid = AXI_ID.
- Burst length: beats_to_4k = (4096 - addr[11:0]) >> log2(STRB_WIDTH); burst beats = min(remaining, beats_to_4k). Remaining is 9 bits (up to 256). Next burst address = addr + beats*STRB_WIDTH, computed modulo 2^ADDR_WIDTH (wraps).
- Read FSM, states IDLE, AR, DATA:
  - IDLE: rd_cmd_ready = 1. On handshake, latch addr and remaining = len+1, then go to AR.
  - AR: arvalid = 1 from the cycle after acceptance. It holds with stable fields until arready, then goes to DATA.
  - DATA: pure combinational pass-through. rd_data = rdata, rd_data_err = rresp[1], rd_data_valid = rvalid, rready = rd_data_ready. No added latency.
  - rd_data_last = rlast AND this burst is the final one.
  - On an rlast handshake: go to AR if beats remain, else IDLE. rd_cmd_ready rises the following cycle.
  - rid is ignored.
- Write FSM, states IDLE, AW, DATA, RESP:
  - IDLE: wr_cmd_ready = 1. A handshake latches the command and clears err_acc.
  - AW: awvalid = 1 until awready, then go to DATA.
  - DATA: wvalid = wr_data_valid and wr_data_ready = wready, both gated to this state. wdata/wstrb pass through. wlast = 1 when the burst beat counter equals 0. A wlast handshake goes to RESP.
  - RESP: bready = 1. On bvalid, err_acc |= bresp[1]. Go to AW if beats remain. Otherwise pulse wr_done one cycle with wr_done_err = err_acc | bresp[1], then go to IDLE.
  - W is never issued before the AW handshake for the same burst.
- rd_data_valid and wvalid follow AXI rules: once asserted they hold until handshake (the upstream source guarantees this). awvalid/arvalid never drop before ready.
- Simultaneous read and write commands are accepted in the same cycle; the two paths never interact.
- rd_cmd_len = 0 gives a single beat with arlen = 0 and rd_data_last on that beat.

Decomposition:
- Package axi_pkg: BURST_INCR = 2'b01, RESP_OKAY/EXOKAY/SLVERR/DECERR, CACHE_DEFAULT = 4'b0011, the 4096 boundary constant, state enums for both FSMs.
- One natural sub-module, axi_burst_split: given addr and remaining, it returns burst beats and next addr. Instantiate it twice, once per path.

Test Plan:
- Read, DATA_WIDTH 32, addr 0x0100, len 0 -> one AR (araddr 0x0100, arlen 0, arsize 2, arburst 1); one beat out with rd_data_last = 1; rd_cmd_ready high again 1 cycle after rlast.
- Read at addr 0x0FF0, len 7 -> AR 0x0FF0 arlen 3, then AR 0x1000 arlen 3; rd_data_last only on the 8th beat, not on the first rlast.
- Write at addr 0x0000, len 255, with random wready/awready stalls -> one AW with awlen 255; wlast exactly on beat 256; wr_done pulses once; wr_done_err = 0.
- Write crossing 4 KB (addr 0x0FF8, len 3), first B = SLVERR, second B = OKAY -> two bursts with awlen 1 and 1; wr_done_err = 1.
- Read with rd_data_ready deasserted for 10 cycles mid-burst -> rready low for those cycles; no beat lost or duplicated; data order preserved.
- Assert rst during write DATA state -> next cycle wvalid = 0, awvalid = 0, wr_cmd_ready = 1; a new command then completes normally.
